// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
//   state_e  : sequencer FSM states
//   cause_e  : encoding of the fault_cause output
//   DEFAULT_RESET_VECTOR / DEFAULT_TIMEOUT : parameter defaults
package fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam int          DEFAULT_TIMEOUT      = 16;

   typedef enum logic [2:0] {
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_HALTED,
      ST_FAULT
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_TIMEOUT  = 2'b10
   } cause_e;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory request/response bus.
//   imem_req_valid / imem_req_ready : request handshake
//   imem_addr                       : fetch address
//   imem_rsp_valid / imem_rsp_data  : returned instruction word (no backpressure)
// master = fetch sequencer side, slave = memory side.
interface fetch_sequencer_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_watchdog.sv
// Response watchdog for the fetch sequencer.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count back to zero
//   enable   : count this cycle
//   expired  : this is the TIMEOUT-th enabled cycle since the last clear
module fetch_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] count;

   // count holds (cycles already spent) so the TIMEOUT-th cycle sees TIMEOUT-1
   assign expired = enable && (count == W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests one word at pc, waits for the
// response under a watchdog, presents it to the datapath and advances to
// the externally computed pc_next on retirement.
//   clk, rst       : clock, synchronous active-high reset
//   imem           : instruction memory bus (master side)
//   pc, instr      : current instruction and its address
//   instr_valid    : instr/pc presented to the datapath
//   instr_ready    : datapath retires the presented instruction
//   pc_next        : next pc from the pc selection logic
//   halt           : stop after the current retirement
//   fault          : sticky fetch fault, fault_cause gives the reason
//   retired_count  : free-running count of retired instructions
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_REQ    | request at pc outstanding, waiting for imem_req_ready
// ST_WAIT   | request accepted, waiting for response, watchdog running
// ST_HOLD   | instr/pc presented, waiting for instr_ready
// ST_HALTED | stopped on halt, resumes at pc once halt drops
// ST_FAULT  | terminal until reset
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          TIMEOUT      = DEFAULT_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   fetch_sequencer_if.master   imem,
   output logic [31:0]         pc,
   output logic [31:0]         instr,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic [31:0]         pc_next,
   input  logic                halt,
   output logic                fault,
   output logic [1:0]          fault_cause,
   output logic [31:0]         retired_count
);

   state_e state_q, state_d;
   cause_e cause_q, cause_d;

   logic req_valid;
   logic load_instr;
   logic retire;
   logic set_fault;
   logic wd_clear;
   logic wd_enable;
   logic wd_expired;

   fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_valid   = 1'b0;
      instr_valid = 1'b0;
      load_instr  = 1'b0;
      retire      = 1'b0;
      set_fault   = 1'b0;
      cause_d     = CAUSE_NONE;
      wd_clear    = 1'b1;
      wd_enable   = 1'b0;

      case (state_q)
         ST_REQ: begin
            req_valid = 1'b1;
            if (imem.imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            wd_clear  = 1'b0;
            wd_enable = 1'b1;
            // a response in the expiry cycle still wins
            if (imem.imem_rsp_valid) begin
               load_instr = 1'b1;
               state_d    = ST_HOLD;
            end else if (wd_expired) begin
               set_fault = 1'b1;
               cause_d   = CAUSE_TIMEOUT;
               state_d   = ST_FAULT;
            end
         end
         ST_HOLD: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               retire = 1'b1;
               if (misaligned(pc_next)) begin
                  set_fault = 1'b1;
                  cause_d   = CAUSE_MISALIGN;
                  state_d   = ST_FAULT;
               end else if (halt) begin
                  state_d = ST_HALTED;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_HALTED: begin
            if (!halt) begin
               state_d = ST_REQ;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_VECTOR;
         instr         <= '0;
         fault         <= 1'b0;
         cause_q       <= CAUSE_NONE;
         retired_count <= '0;
      end else begin
         if (load_instr) begin
            instr <= imem.imem_rsp_data;
         end
         // the faulting target is still committed so software can inspect it
         if (retire) begin
            pc            <= pc_next;
            retired_count <= retired_count + 32'd1;
         end
         if (set_fault) begin
            fault   <= 1'b1;
            cause_q <= cause_d;
         end
      end
   end

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_addr      = pc;
   assign fault_cause         = cause_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, instr, pc_next, retired_count;
   logic        instr_valid, instr_ready, halt, fault;
   logic [1:0]  fault_cause;

   always #5 clk = ~clk;

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .RESET_VECTOR (32'h0000_0000),
      .TIMEOUT      (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (bus.master),
      .pc            (pc),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .pc_next       (pc_next),
      .halt          (halt),
      .fault         (fault),
      .fault_cause   (fault_cause),
      .retired_count (retired_count)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errs   = 0;
   logic [31:0] m_pc;
   logic [31:0] m_retired;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      instr_ready        = 1'b0;
      halt               = 1'b0;
      pc_next            = 32'h0;
      step();
      step();
      rst       = 1'b0;
      m_pc      = 32'h0;
      m_retired = 32'h0;
      exp_q.delete();
   endtask

   // One complete instruction: rdy_wait cycles of backpressure, response in
   // WAIT cycle rsp_wait+1, hold_wait cycles before retirement.
   task automatic fetch_one(input int rdy_wait, input int rsp_wait, input int hold_wait,
                            input logic [31:0] npc, input logic hlt, input logic junk);
      exp_t e;
      for (int i = 0; i < rdy_wait; i++) begin
         chk("req_valid_stall", bus.imem_req_valid, 1);
         chk("addr_stable", bus.imem_addr, m_pc);
         bus.imem_rsp_valid = junk;
         bus.imem_rsp_data  = 32'hBAD0_0000 | i;
         step();
      end
      chk("req_valid", bus.imem_req_valid, 1);
      chk("req_addr", bus.imem_addr, m_pc);
      chk("no_iv_in_req", instr_valid, 0);
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = junk;
      bus.imem_rsp_data  = 32'hBAD1_0000;
      exp_q.push_back('{pc: m_pc, word: word_of(m_pc)});
      step();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      chk("req_drop", bus.imem_req_valid, 0);
      for (int i = 0; i < rsp_wait; i++) begin
         chk("wait_no_iv", instr_valid, 0);
         chk("wait_no_fault", fault, 0);
         step();
      end
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word_of(m_pc);
      step();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'hBAD2_0000;
      chk("hold_iv", instr_valid, 1);
      chk("hold_no_req", bus.imem_req_valid, 0);
      for (int i = 0; i < hold_wait; i++) begin
         instr_ready = 1'b0;
         pc_next     = 32'hDEAD_BEE0;
         bus.imem_rsp_valid = 1'b1;
         step();
         bus.imem_rsp_valid = 1'b0;
         chk("hold_iv_stable", instr_valid, 1);
         chk("hold_pc_stable", pc, m_pc);
      end
      chk("sb_size", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ret_pc", pc, e.pc);
         chk("ret_instr", instr, e.word);
      end
      instr_ready = 1'b1;
      pc_next     = npc;
      halt        = hlt;
      step();
      instr_ready = 1'b0;
      m_pc        = npc;
      m_retired   = m_retired + 32'd1;
      chk("retired", retired_count, m_retired);
      chk("pc_upd", pc, m_pc);
      chk("iv_drop", instr_valid, 0);
   endtask

   initial begin
      do_reset();
      chk("rst_req_valid", bus.imem_req_valid, 1);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_iv", instr_valid, 0);
      chk("rst_fault", fault, 0);
      chk("rst_cause", fault_cause, 0);
      chk("rst_retired", retired_count, 0);

      // zero-wait memory, sequential pcs 0x0, 0x4, 0x8
      for (int k = 0; k < 3; k++) begin
         fetch_one(0, 0, 0, m_pc + 32'd4, 1'b0, 1'b0);
      end
      chk("three_retired", retired_count, 32'd3);
      chk("pc_after_three", bus.imem_addr, 32'hC);

      // response during acceptance cycle must be ignored; hold stability
      fetch_one(0, 0, 2, m_pc + 32'd4, 1'b0, 1'b1);
      chk("pc_0x10", pc, 32'h10);

      // 5 cycles of backpressure at 0x10 with stray responses in REQ
      fetch_one(5, 3, 0, m_pc + 32'd4, 1'b0, 1'b1);

      // response in the 16th WAIT cycle, then halt at retirement
      fetch_one(0, 15, 0, m_pc + 32'd4, 1'b1, 1'b0);
      chk("late_rsp_no_fault", fault, 0);
      for (int i = 0; i < 4; i++) begin
         chk("halted_no_req", bus.imem_req_valid, 0);
         chk("halted_no_iv", instr_valid, 0);
         step();
      end
      halt = 1'b0;
      step();
      chk("resume_req", bus.imem_req_valid, 1);
      chk("resume_addr", bus.imem_addr, 32'h18);

      // misaligned target
      fetch_one(0, 0, 0, 32'h22, 1'b0, 1'b0);
      chk("mis_fault", fault, 1);
      chk("mis_cause", fault_cause, 2'b01);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("mis_no_req", bus.imem_req_valid, 0);
         chk("mis_fault_held", fault, 1);
         chk("mis_cause_held", fault_cause, 2'b01);
      end

      // reset while waiting, response coincident with reset and afterwards
      do_reset();
      chk("rst2_fault", fault, 0);
      chk("rst2_cause", fault_cause, 0);
      chk("rst2_retired", retired_count, 0);
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      step();
      rst                = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBAD3_0000;
      step();
      rst = 1'b0;
      chk("mid_rst_instr", instr, 32'h0);
      for (int i = 0; i < 2; i++) begin
         chk("stale_req", bus.imem_req_valid, 1);
         chk("stale_addr", bus.imem_addr, 32'h0);
         chk("stale_iv", instr_valid, 0);
         step();
      end
      bus.imem_rsp_valid = 1'b0;
      chk("stale_instr", instr, 32'h0);
      m_pc      = 32'h0;
      m_retired = 32'h0;
      exp_q.delete();
      fetch_one(0, 0, 0, 32'h4, 1'b0, 1'b0);

      // watchdog expiry: no response for 16 WAIT cycles
      chk("to_addr", bus.imem_addr, 32'h4);
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk("to_pending", fault, 0);
         step();
      end
      chk("to_cycle16_no_fault", fault, 0);
      step();
      chk("to_fault", fault, 1);
      chk("to_cause", fault_cause, 2'b10);
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBAD4_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("to_no_req", bus.imem_req_valid, 0);
         chk("to_no_iv", instr_valid, 0);
         chk("to_cause_held", fault_cause, 2'b10);
      end
      bus.imem_rsp_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL be the maximum cycles spent waiting for an imem response.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 imem_req_valid  output  1  SHALL indicate a fetch request.
REQ-006 imem_req_ready  input  1  SHALL indicate the memory accepts the request.
REQ-007 imem_addr  output  32  SHALL be the fetch address, equal to pc.
REQ-008 imem_rsp_valid  input  1  SHALL indicate that imem_rsp_data is valid.
REQ-009 imem_rsp_data  input  32  SHALL be the returned instruction word.
REQ-010 pc  output  32  SHALL be the address of the current instruction.
REQ-011 instr  output  32  SHALL be the registered instruction word.
REQ-012 instr_valid  output  1  SHALL indicate that instr/pc are presented to the datapath.
REQ-013 instr_ready  input  1  SHALL indicate that the datapath retires the presented instruction this cycle.
REQ-014 pc_next  input  32  SHALL be the next-PC value from the PC selection logic.
REQ-015 halt  input  1  SHALL request a stop after the current retirement.
REQ-016 fault  output  1  SHALL be the sticky fetch-fault flag.
REQ-017 fault_cause  output  2  SHALL be 00 none, 01 misaligned target, 10 response timeout.
REQ-018 retired_count  output  32  SHALL be the count of retired instructions.

Function
REQ-019 FSM states SHALL be REQ, WAIT, HOLD, HALTED and FAULT.
REQ-020 REQ: imem_req_valid=1; on valid&ready -> WAIT; imem_addr SHALL stay stable while it is unaccepted.
REQ-021 WAIT: imem_rsp_valid SHALL latch imem_rsp_data into instr -> HOLD; the earliest response cycle is the cycle after acceptance.
REQ-022 A response arriving in the same cycle as acceptance, or in any state other than WAIT, SHALL be ignored.
REQ-023 WAIT watchdog: the counter clears on entry and increments each cycle; at TIMEOUT cycles with no response -> FAULT, cause 10.
REQ-024 A response and the timeout in the same cycle SHALL favour the response.
REQ-025 HOLD: instr_valid=1; instr and pc SHALL be stable until instr_ready.
REQ-026 On HOLD&instr_ready: pc <= pc_next and retired_count increments; the following checks apply in priority order.
REQ-027 Priority 1: pc_next[1:0]!=0 -> FAULT, cause 01; pc is still updated to the faulting value.
REQ-028 Priority 2: halt=1 -> HALTED.
REQ-029 Priority 3: otherwise -> REQ.
REQ-030 HALTED: no requests; halt=0 -> REQ at the current pc.
REQ-031 FAULT SHALL be terminal until rst: no requests, and fault/fault_cause held.
REQ-032 retired_count SHALL wrap 32'hFFFF_FFFF -> 0 without any flag.
REQ-033 Fetch latency SHALL be 1 cycle from response to instr_valid; minimum 3 cycles per instruction with a zero-wait memory.
REQ-034 imem_req_valid and instr_valid SHALL never be asserted in the same cycle.

Reset
REQ-035 On rst: state=REQ, pc=RESET_VECTOR, instr=0, instr_valid=0, fault=0, fault_cause=00, retired_count=0 and watchdog=0.
REQ-036 imem_req_valid SHALL assert in the first cycle after rst deasserts.
REQ-037 rst mid-transaction SHALL abandon the outstanding request; any response arriving afterwards SHALL be ignored until a new request is accepted.
REQ-038 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-039 A shared package fetch_pkg SHALL hold the state enum, the fault_cause enum and the default reset-vector constant.
REQ-040 The watchdog SHALL be one sub-module, fetch_watchdog, with clear, enable, TIMEOUT parameter and expired output.
REQ-041 Next-PC computation SHALL stay outside this block; only pc_next is consumed.

Verification
REQ-042 Zero-wait memory, 3 retirements, pc_next=pc+4 -> imem_addr 0x0, 0x4, 0x8 and retired_count=3.
REQ-043 imem_req_ready held low 5 cycles with pc=0x10 -> imem_addr stays 0x10 and is accepted on the 6th cycle.
REQ-044 Retire with pc_next=0x22 -> FAULT, fault_cause=01, pc=0x22 and no further requests.
REQ-045 No response for 16 cycles -> FAULT, cause 10; the same test with the response at cycle 16 -> HOLD, no fault.
REQ-046 halt=1 at retirement -> HALTED for 4 cycles; halt=0 -> request at the next pc.
REQ-047 rst in WAIT, then a stale response -> ignored, and the fetch restarts at RESET_VECTOR.
